// File: rtl/sfq_emu_pkg.sv
// Shared types and helpers for the cycle-based SFQ cell emulation.
// Pulses are toggle-encoded: any change of a line between two samples is one pulse.
package sfq_emu_pkg;

   typedef enum logic {
      ST_EMPTY  = 1'b0,
      ST_STORED = 1'b1
   } chanState_e;

   function automatic logic pulseDetect(input logic cur, input logic prev);
      return cur ^ prev;
   endfunction

   // Increment that sticks at the all-ones value of a counter 'width' bits wide.
   function automatic logic [31:0] satInc(input logic [31:0] value, input int unsigned width);
      logic [31:0] maxVal;
      maxVal = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
      return (value >= maxVal) ? maxVal : value + 32'd1;
   endfunction

endpackage

// File: rtl/sfq_clocked_cell_ch.sv
// One emulated SFQ clocked inverter/buffer channel: storage state, setup/hold
// window tracking, output latency pipeline and the sticky violation flag.
module sfq_clocked_cell_ch
   import sfq_emu_pkg::*;
#(
   parameter bit INV       = 1'b1,
   parameter int DELAY_CYC = 2,
   parameter int SETUP_CYC = 1,
   parameter int HOLD_CYC  = 2
) (
   input  logic clk_i,
   input  logic rst_n_i,
   input  logic a_tgl_i,
   input  logic clkPulse_i,
   input  logic violClr_i,
   output logic q_tgl_o,
   output logic viol_o,
   output logic violEvent_o
);

   localparam int SW = $clog2(SETUP_CYC + 2);
   localparam int HW = $clog2(HOLD_CYC + 2);

   logic                 aPrev_q;
   chanState_e           state_q, state_d;
   logic [SW-1:0]        setupCnt_q, setupCnt_d;
   logic [HW-1:0]        holdCnt_q, holdCnt_d;
   logic [DELAY_CYC-1:0] pipe_q, pipe_d;
   logic                 acc_q, acc_d;
   logic                 viol_q, viol_d;
   logic                 dataPulse, fire, violEvent;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         aPrev_q    <= 1'b0;
         state_q    <= ST_EMPTY;
         setupCnt_q <= '0;
         holdCnt_q  <= '0;
         pipe_q     <= '0;
         acc_q      <= 1'b0;
         viol_q     <= 1'b0;
      end else begin
         aPrev_q    <= a_tgl_i;
         state_q    <= state_d;
         setupCnt_q <= setupCnt_d;
         holdCnt_q  <= holdCnt_d;
         pipe_q     <= pipe_d;
         acc_q      <= acc_d;
         viol_q     <= viol_d;
      end
   end

   // Clock evaluates the pre-cycle state; a same-cycle data pulse lands in the next window.
   always_comb begin
      dataPulse = pulseDetect(a_tgl_i, aPrev_q);
      violEvent = (clkPulse_i & (dataPulse | (setupCnt_q != '0)))
                | (dataPulse & (holdCnt_q != '0));
      fire      = 1'b0;
      state_d   = state_q;
      if (clkPulse_i) begin
         fire    = INV ? (state_q == ST_EMPTY) : (state_q == ST_STORED);
         state_d = dataPulse ? ST_STORED : ST_EMPTY;
      end else if (dataPulse) begin
         state_d = ST_STORED;
      end

      setupCnt_d = setupCnt_q;
      if (dataPulse) begin
         setupCnt_d = SW'(SETUP_CYC);
      end else if (setupCnt_q != '0) begin
         setupCnt_d = setupCnt_q - SW'(1);
      end

      holdCnt_d = holdCnt_q;
      if (clkPulse_i) begin
         holdCnt_d = HW'(HOLD_CYC);
      end else if (holdCnt_q != '0) begin
         holdCnt_d = holdCnt_q - HW'(1);
      end

      // Each fired evaluation travels independently, so back-to-back clocks never merge.
      pipe_d    = '0;
      pipe_d[0] = fire;
      for (int k = 1; k < DELAY_CYC; k++) begin
         pipe_d[k] = pipe_q[k-1];
      end
      acc_d = acc_q ^ pipe_q[DELAY_CYC-1];

      viol_d = violClr_i ? 1'b0 : viol_q;
      if (violEvent) begin
         viol_d = 1'b1;
      end
   end

   assign q_tgl_o     = acc_q ^ pipe_q[DELAY_CYC-1];
   assign viol_o      = viol_q;
   assign violEvent_o = violEvent;

endmodule

// File: rtl/sfq_clocked_inv_array.sv
// N-channel SFQ clocked inverter/buffer array sharing one toggle-encoded SFQ clock,
// with min-period checking and a saturating count of cycles containing violations.
module sfq_clocked_inv_array
   import sfq_emu_pkg::*;
#(
   parameter int           N          = 4,
   parameter logic [N-1:0] INV_MASK   = {N{1'b1}},
   parameter int           DELAY_CYC  = 2,
   parameter int           SETUP_CYC  = 1,
   parameter int           HOLD_CYC   = 2,
   parameter int           MINPER_CYC = 3,
   parameter int           CNT_W      = 8
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic [N-1:0]     a_tgl_i,
   input  logic             sclk_tgl_i,
   input  logic             viol_clr_i,
   output logic [N-1:0]     q_tgl_o,
   output logic [N-1:0]     viol_o,
   output logic             clk_viol_o,
   output logic [CNT_W-1:0] viol_cnt_o
);

   localparam int PW    = $clog2(MINPER_CYC + 2);
   localparam int PLOAD = (MINPER_CYC > 0) ? MINPER_CYC - 1 : 0;

   logic             sclkPrev_q;
   logic [PW-1:0]    periodCnt_q, periodCnt_d;
   logic             clkViol_q, clkViol_d;
   logic [CNT_W-1:0] violCnt_q, violCnt_d;
   logic [N-1:0]     chanEvent;
   logic             sclkPulse, clkViolEvent;

   for (genvar i = 0; i < N; i++) begin : g_ch
      sfq_clocked_cell_ch #(
         .INV       (INV_MASK[i]),
         .DELAY_CYC (DELAY_CYC),
         .SETUP_CYC (SETUP_CYC),
         .HOLD_CYC  (HOLD_CYC)
      ) u_ch (
         .clk_i       (clk_i),
         .rst_n_i     (rst_n_i),
         .a_tgl_i     (a_tgl_i[i]),
         .clkPulse_i  (sclkPulse),
         .violClr_i   (viol_clr_i),
         .q_tgl_o     (q_tgl_o[i]),
         .viol_o      (viol_o[i]),
         .violEvent_o (chanEvent[i])
      );
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         sclkPrev_q  <= 1'b0;
         periodCnt_q <= '0;
         clkViol_q   <= 1'b0;
         violCnt_q   <= '0;
      end else begin
         sclkPrev_q  <= sclk_tgl_i;
         periodCnt_q <= periodCnt_d;
         clkViol_q   <= clkViol_d;
         violCnt_q   <= violCnt_d;
      end
   end

   // periodCnt is zero out of reset, so the very first clock pulse can never violate.
   always_comb begin
      sclkPulse    = pulseDetect(sclk_tgl_i, sclkPrev_q);
      clkViolEvent = sclkPulse & (periodCnt_q != '0);

      periodCnt_d = periodCnt_q;
      if (sclkPulse) begin
         periodCnt_d = PW'(PLOAD);
      end else if (periodCnt_q != '0) begin
         periodCnt_d = periodCnt_q - PW'(1);
      end

      clkViol_d = viol_clr_i ? 1'b0 : clkViol_q;
      if (clkViolEvent) begin
         clkViol_d = 1'b1;
      end

      violCnt_d = viol_clr_i ? '0 : violCnt_q;
      if (clkViolEvent | (|chanEvent)) begin
         violCnt_d = CNT_W'(satInc(32'(violCnt_d), CNT_W));
      end
   end

   assign clk_viol_o = clkViol_q;
   assign viol_cnt_o = violCnt_q;

endmodule

// File: tb/tb_sfq_clocked_inv_array.sv
// Directed bench for sfq_clocked_inv_array: default all-inverter instance plus a
// mixed inverter/buffer instance driven by the same stimulus.
module tb_sfq_clocked_inv_array;

   logic       clk = 1'b0;
   logic       rstN;
   logic [3:0] aTgl;
   logic       sclkTgl;
   logic       violClr;
   logic [3:0] qTgl, viol, qTglM, violM;
   logic       clkViol, clkViolM;
   logic [7:0] violCnt, violCntM;

   int cyc;
   int testsRun;
   int testsFailed;

   always #5 clk = ~clk;

   sfq_clocked_inv_array dut (
      .clk_i      (clk),
      .rst_n_i    (rstN),
      .a_tgl_i    (aTgl),
      .sclk_tgl_i (sclkTgl),
      .viol_clr_i (violClr),
      .q_tgl_o    (qTgl),
      .viol_o     (viol),
      .clk_viol_o (clkViol),
      .viol_cnt_o (violCnt)
   );

   sfq_clocked_inv_array #(.INV_MASK(4'b0101)) dutMask (
      .clk_i      (clk),
      .rst_n_i    (rstN),
      .a_tgl_i    (aTgl),
      .sclk_tgl_i (sclkTgl),
      .viol_clr_i (violClr),
      .q_tgl_o    (qTglM),
      .viol_o     (violM),
      .clk_viol_o (clkViolM),
      .viol_cnt_o (violCntM)
   );

   // Inputs change 1 time unit after a rising edge; cycle n is the interval after the n-th edge.
   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic goTo(input int n);
      while (cyc < n) tick();
   endtask

   task automatic doReset();
      @(posedge clk);
      #1;
      rstN    = 1'b0;
      aTgl    = 4'b0000;
      sclkTgl = 1'b0;
      violClr = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rstN = 1'b1;
      cyc  = 0;
   endtask

   task automatic pulseData(input int ch);
      aTgl[ch] = ~aTgl[ch];
   endtask

   task automatic pulseSclk();
      sclkTgl = ~sclkTgl;
   endtask

   task automatic test_reset();
      doReset();
      testsRun++;
      if (qTgl !== 4'b0000) begin testsFailed++; $display("[TB] FAIL reset q_tgl: got %b expected 0000", qTgl); end
      testsRun++;
      if (viol !== 4'b0000) begin testsFailed++; $display("[TB] FAIL reset viol: got %b expected 0000", viol); end
      testsRun++;
      if (clkViol !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset clk_viol: got %b expected 0", clkViol); end
      testsRun++;
      if (violCnt !== 8'd0) begin testsFailed++; $display("[TB] FAIL reset viol_cnt: got %0d expected 0", violCnt); end
      testsRun++;
      if (qTglM !== 4'b0000) begin testsFailed++; $display("[TB] FAIL reset mask q_tgl: got %b expected 0000", qTglM); end
   endtask

   task automatic test_no_data();
      doReset();
      goTo(20); pulseSclk();
      goTo(21);
      testsRun++;
      if (qTgl !== 4'b0000) begin testsFailed++; $display("[TB] FAIL nodata q_tgl@21: got %b expected 0000", qTgl); end
      goTo(22);
      testsRun++;
      if (qTgl !== 4'b1111) begin testsFailed++; $display("[TB] FAIL nodata q_tgl@22: got %b expected 1111", qTgl); end
      testsRun++;
      if (qTglM !== 4'b0101) begin testsFailed++; $display("[TB] FAIL nodata mask q_tgl@22: got %b expected 0101", qTglM); end
      testsRun++;
      if (viol !== 4'b0000 || clkViol !== 1'b0 || violCnt !== 8'd0) begin
         testsFailed++;
         $display("[TB] FAIL nodata violations: got viol=%b clk=%b cnt=%0d expected 0/0/0", viol, clkViol, violCnt);
      end
   endtask

   task automatic test_data_blocks();
      doReset();
      goTo(10); pulseData(0);
      goTo(20); pulseSclk();
      goTo(22);
      testsRun++;
      if (qTgl !== 4'b1110) begin testsFailed++; $display("[TB] FAIL datablock q_tgl@22: got %b expected 1110", qTgl); end
      testsRun++;
      if (viol !== 4'b0000) begin testsFailed++; $display("[TB] FAIL datablock viol: got %b expected 0000", viol); end
   endtask

   task automatic test_inv_mask();
      doReset();
      goTo(10); pulseData(1); pulseData(2);
      goTo(20); pulseSclk();
      goTo(22);
      testsRun++;
      if (qTglM !== 4'b0011) begin testsFailed++; $display("[TB] FAIL invmask mask q_tgl@22: got %b expected 0011", qTglM); end
      testsRun++;
      if (qTgl !== 4'b1001) begin testsFailed++; $display("[TB] FAIL invmask default q_tgl@22: got %b expected 1001", qTgl); end
   endtask

   task automatic test_setup_hold();
      doReset();
      goTo(19); pulseData(1);
      goTo(20); pulseSclk();
      goTo(21);
      testsRun++;
      if (viol !== 4'b0010) begin testsFailed++; $display("[TB] FAIL setup viol@21: got %b expected 0010", viol); end
      testsRun++;
      if (violCnt !== 8'd1) begin testsFailed++; $display("[TB] FAIL setup viol_cnt@21: got %0d expected 1", violCnt); end
      pulseData(2);
      goTo(22);
      testsRun++;
      if (qTgl !== 4'b1101) begin testsFailed++; $display("[TB] FAIL setup q_tgl@22: got %b expected 1101", qTgl); end
      testsRun++;
      if (viol !== 4'b0110) begin testsFailed++; $display("[TB] FAIL hold viol@22: got %b expected 0110", viol); end
      testsRun++;
      if (violCnt !== 8'd2) begin testsFailed++; $display("[TB] FAIL hold viol_cnt@22: got %0d expected 2", violCnt); end
      goTo(30); pulseSclk();
      goTo(32);
      testsRun++;
      if (qTgl !== 4'b0110) begin testsFailed++; $display("[TB] FAIL hold q_tgl@32: got %b expected 0110", qTgl); end
      testsRun++;
      if (violCnt !== 8'd2 || clkViol !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL hold cnt/clk@32: got cnt=%0d clk=%b expected 2/0", violCnt, clkViol);
      end
   endtask

   task automatic test_min_period();
      doReset();
      goTo(20); pulseSclk();
      goTo(22); pulseSclk();
      testsRun++;
      if (qTgl !== 4'b1111) begin testsFailed++; $display("[TB] FAIL minper q_tgl@22: got %b expected 1111", qTgl); end
      goTo(23);
      testsRun++;
      if (clkViol !== 1'b1 || violCnt !== 8'd1) begin
         testsFailed++;
         $display("[TB] FAIL minper clk/cnt@23: got clk=%b cnt=%0d expected 1/1", clkViol, violCnt);
      end
      goTo(24);
      testsRun++;
      if (qTgl !== 4'b0000) begin testsFailed++; $display("[TB] FAIL minper q_tgl@24: got %b expected 0000", qTgl); end
      goTo(30); violClr = 1'b1;
      goTo(31); violClr = 1'b0;
      testsRun++;
      if (clkViol !== 1'b0 || violCnt !== 8'd0 || viol !== 4'b0000) begin
         testsFailed++;
         $display("[TB] FAIL clear@31: got clk=%b cnt=%0d viol=%b expected 0/0/0000", clkViol, violCnt, viol);
      end
   endtask

   task automatic test_clr_collision();
      doReset();
      goTo(20); pulseSclk();
      goTo(22); pulseSclk();
      goTo(23); pulseData(0);
      goTo(24);
      testsRun++;
      if (violCnt !== 8'd2 || viol !== 4'b0001) begin
         testsFailed++;
         $display("[TB] FAIL collide pre@24: got cnt=%0d viol=%b expected 2/0001", violCnt, viol);
      end
      pulseSclk(); violClr = 1'b1;
      goTo(25); violClr = 1'b0;
      testsRun++;
      if (violCnt !== 8'd1) begin testsFailed++; $display("[TB] FAIL collide cnt@25: got %0d expected 1", violCnt); end
      testsRun++;
      if (clkViol !== 1'b1 || viol !== 4'b0001) begin
         testsFailed++;
         $display("[TB] FAIL collide flags@25: got clk=%b viol=%b expected 1/0001", clkViol, viol);
      end
   endtask

   task automatic test_back_to_back();
      doReset();
      goTo(20); pulseSclk();
      goTo(21); pulseSclk();
      goTo(22);
      testsRun++;
      if (qTgl !== 4'b1111) begin testsFailed++; $display("[TB] FAIL b2b q_tgl@22: got %b expected 1111", qTgl); end
      testsRun++;
      if (clkViol !== 1'b1) begin testsFailed++; $display("[TB] FAIL b2b clk_viol@22: got %b expected 1", clkViol); end
      goTo(23);
      testsRun++;
      if (qTgl !== 4'b0000) begin testsFailed++; $display("[TB] FAIL b2b q_tgl@23: got %b expected 0000", qTgl); end
   endtask

   task automatic test_reset_midflight();
      doReset();
      goTo(15); pulseData(0);
      goTo(20); pulseSclk();
      goTo(21);
      rstN = 1'b0; aTgl = 4'b0000; sclkTgl = 1'b0;
      goTo(22);
      testsRun++;
      if (qTgl !== 4'b0000) begin testsFailed++; $display("[TB] FAIL midrst q_tgl@22: got %b expected 0000", qTgl); end
      goTo(25); rstN = 1'b1;
      goTo(26);
      testsRun++;
      if (qTgl !== 4'b0000 || viol !== 4'b0000 || violCnt !== 8'd0) begin
         testsFailed++;
         $display("[TB] FAIL midrst state@26: got q=%b viol=%b cnt=%0d expected 0000/0000/0", qTgl, viol, violCnt);
      end
      goTo(40); pulseSclk();
      goTo(41);
      testsRun++;
      if (qTgl !== 4'b0000) begin testsFailed++; $display("[TB] FAIL midrst q_tgl@41: got %b expected 0000", qTgl); end
      goTo(42);
      testsRun++;
      if (qTgl !== 4'b1111) begin testsFailed++; $display("[TB] FAIL midrst q_tgl@42: got %b expected 1111", qTgl); end
   endtask

   task automatic test_saturation();
      doReset();
      for (int c = 10; c < 310; c++) begin
         goTo(c);
         if (c == 20) begin
            testsRun++;
            if (violCnt !== 8'd9) begin testsFailed++; $display("[TB] FAIL sat cnt@20: got %0d expected 9", violCnt); end
         end
         pulseSclk();
      end
      goTo(311);
      testsRun++;
      if (violCnt !== 8'd255) begin testsFailed++; $display("[TB] FAIL sat cnt@311: got %0d expected 255", violCnt); end
      testsRun++;
      if (clkViol !== 1'b1) begin testsFailed++; $display("[TB] FAIL sat clk_viol@311: got %b expected 1", clkViol); end
   endtask

   initial begin
      testsRun    = 0;
      testsFailed = 0;
      cyc         = 0;
      rstN        = 1'b0;
      aTgl        = 4'b0000;
      sclkTgl     = 1'b0;
      violClr     = 1'b0;
      test_reset();
      test_no_data();
      test_data_blocks();
      test_inv_mask();
      test_setup_hold();
      test_min_period();
      test_clr_collision();
      test_back_to_back();
      test_reset_midflight();
      test_saturation();
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
